// File: rtl/convn_valid_mul_share.sv
// convn_valid_mul_share
//
// Time-shares one external signed DW x DW multiplier (low PW product bits)
// among NREQ requesters. A round-robin arbiter picks one operand pair per
// cycle into the operand stage (p1), which drives the multiplier inputs from
// registers. The product is captured into the response stage (p2) and
// returned on a single response channel tagged with the requester index.
//
// Ports:
//   ap_clk, ap_rst_n      clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot or 0)
//   req_a, req_b          packed operands, requester i at [i*DW +: DW]
//   mul_din0, mul_din1    registered operands to the external multiplier
//   mul_dout              combinational product from the external multiplier
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_id      product and owning requester index
//
// Optional build macro CONVN_MUL_SHARE_PERF_EN adds saturating 16-bit
// counters perf_ops (accepted requests) and perf_stall (cycles with a valid
// request and no ready).

module convn_valid_mul_share #(
  parameter int NREQ = 4,
  parameter int DW   = 10,
  parameter int PW   = 10,
  parameter int IDW  = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DW-1:0]     req_a,
  input  logic [NREQ*DW-1:0]     req_b,
  output logic signed [DW-1:0]   mul_din0,
  output logic signed [DW-1:0]   mul_din1,
  input  logic signed [PW-1:0]   mul_dout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PW-1:0]          rsp_data,
  output logic [IDW-1:0]         rsp_id
`ifdef CONVN_MUL_SHARE_PERF_EN
  ,
  output logic [15:0]            perf_ops,
  output logic [15:0]            perf_stall
`endif
);

  logic                  vld_p1;
  logic signed [DW-1:0]  a_p1;
  logic signed [DW-1:0]  b_p1;
  logic [IDW-1:0]        id_p1;

  logic                  vld_p2;
  logic signed [PW-1:0]  data_p2;
  logic [IDW-1:0]        id_p2;

  logic [IDW-1:0]        rr;

  logic                  s2_free;
  logic                  s1_adv;
  logic                  s1_free;

  logic                  hit_hi;
  logic                  hit_lo;
  logic [IDW-1:0]        gid_hi;
  logic [IDW-1:0]        gid_lo;
  logic [IDW-1:0]        gid;
  logic                  found;
  logic [NREQ-1:0]       grant;
  logic                  accept;
  logic signed [DW-1:0]  a_sel;
  logic signed [DW-1:0]  b_sel;

`ifdef CONVN_MUL_SHARE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign s2_free = !vld_p2 | rsp_ready;
  assign s1_adv  = vld_p1 & s2_free;
  assign s1_free = !vld_p1 | s1_adv;

  // Round-robin search: the lowest valid index at or above rr wins; if none,
  // the lowest valid index below rr wraps around and wins.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    gid_hi = '0;
    gid_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) >= rr) begin
          hit_hi = 1'b1;
          gid_hi = IDW'(i);
        end else begin
          hit_lo = 1'b1;
          gid_lo = IDW'(i);
        end
      end
    end
    gid   = hit_hi ? gid_hi : gid_lo;
    found = hit_hi | hit_lo;
  end

  always_comb begin
    grant = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (found && (IDW'(i) == gid)) begin
        grant[i] = 1'b1;
        a_sel    = req_a[i*DW +: DW];
        b_sel    = req_b[i*DW +: DW];
      end
    end
  end

  // Reset gates ready combinationally: with the pipeline cleared s1_free is
  // high, so without this a held req_valid would see ready during reset.
  assign req_ready = (s1_free && ap_rst_n) ? grant : '0;
  assign accept    = found & s1_free & ap_rst_n;

  // ---- stage p1: operand registers feeding the multiplier ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      id_p1  <= '0;
      rr     <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      a_p1   <= a_sel;
      b_p1   <= b_sel;
      id_p1  <= gid;
      rr     <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
    end else if (s1_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  assign mul_din0 = a_p1;
  assign mul_din1 = b_p1;

  // ---- stage p2: response registers capturing the product ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      id_p2   <= '0;
    end else if (s1_adv) begin
      vld_p2  <= 1'b1;
      data_p2 <= mul_dout;
      id_p2   <= id_p1;
    end else if (rsp_ready) begin
      vld_p2  <= 1'b0;
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_data  = data_p2;
  assign rsp_id    = id_p2;

`ifdef CONVN_MUL_SHARE_PERF_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (accept) begin
        perf_ops <= sat_inc(perf_ops);
      end
      if ((|req_valid) && (req_ready == '0)) begin
        perf_stall <= sat_inc(perf_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_convn_valid_mul_share.sv
module tb_convn_valid_mul_share;

  logic               clk;
  logic               ap_rst_n;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [39:0]        req_a;
  logic [39:0]        req_b;
  logic signed [9:0]  mul_din0;
  logic signed [9:0]  mul_din1;
  logic signed [9:0]  mul_dout;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [9:0]         rsp_data;
  logic [1:0]         rsp_id;
`ifdef CONVN_MUL_SHARE_PERF_EN
  logic [15:0]        perf_ops;
  logic [15:0]        perf_stall;
`endif

  logic signed [9:0]  oa [4];
  logic signed [9:0]  ob [4];
  logic signed [19:0] prod;

  int errs;
  int checks;

  assign req_a = {oa[3], oa[2], oa[1], oa[0]};
  assign req_b = {ob[3], ob[2], ob[1], ob[0]};

  // Behavioural 10s x 10s -> low 10 bits multiplier
  assign prod     = mul_din0 * mul_din1;
  assign mul_dout = prod[9:0];

  convn_valid_mul_share dut (
    .ap_clk    (clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef CONVN_MUL_SHARE_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] low_prod(input logic signed [9:0] a, input logic signed [9:0] b);
    logic signed [19:0] p;
    p = a * b;
    return p[9:0];
  endfunction

  task automatic test_reset;
    ap_rst_n  = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'h0) begin errs++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (mul_din0 !== 10'h000) begin errs++; $display("FAIL reset_din0 got=%h exp=000", mul_din0); end
    checks++; if (mul_din1 !== 10'h000) begin errs++; $display("FAIL reset_din1 got=%h exp=000", mul_din1); end
    ap_rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    req_valid = 4'h0;
  endtask

  task automatic test_single;
    @(negedge clk);
    oa[2] = 10'sd3; ob[2] = -10'sd4; req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL single_early got=%b exp=0", rsp_valid); end
    checks++; if (mul_din0 !== 10'h003) begin errs++; $display("FAIL single_din0 got=%h exp=003", mul_din0); end
    checks++; if (mul_din1 !== 10'h3FC) begin errs++; $display("FAIL single_din1 got=%h exp=3fc", mul_din1); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 10'h3F4) begin errs++; $display("FAIL single_data got=%h exp=3f4", rsp_data); end
    checks++; if (rsp_id !== 2'd2) begin errs++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL single_once got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin;
    int         exp_g [6];
    logic [9:0] exp_p [4];
    exp_g = '{0, 1, 2, 3, 0, 1};
    exp_p = '{10'h002, 10'h006, 10'h00C, 10'h014};
    // rr is 3 after the single test: one op from requester 3 returns it to 0
    @(negedge clk);
    oa[3] = -10'sd2; ob[3] = 10'sd5; req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL rr_prime_ready got=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 10'h3F6) begin
      errs++; $display("FAIL rr_prime_rsp got=%b/%0d/%h exp=1/3/3f6", rsp_valid, rsp_id, rsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      oa[i] = 10'(i + 1);
      ob[i] = 10'(i + 2);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) req_valid = 4'hF;
      if (j == 6) req_valid = 4'h0;
      #1;
      if (j < 6) begin
        checks++; if (req_ready !== (4'b0001 << exp_g[j])) begin
          errs++; $display("FAIL rr_grant[%0d] got=%b exp_id=%0d", j, req_ready, exp_g[j]);
        end
      end
      if (j >= 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[j-2]) || rsp_data !== exp_p[exp_g[j-2]]) begin
          errs++; $display("FAIL rr_rsp[%0d] got=%b/%0d/%h exp=1/%0d/%h", j, rsp_valid, rsp_id, rsp_data,
                           exp_g[j-2], exp_p[exp_g[j-2]]);
        end
      end
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rr_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_truncation;
    @(negedge clk);
    oa[2] = -10'sd512; ob[2] = -10'sd512; req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL trunc_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 10'h000) begin
      errs++; $display("FAIL trunc_min got=%b/%h exp=1/000", rsp_valid, rsp_data);
    end
    oa[2] = 10'sd31; ob[2] = 10'sd33; req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 10'h3FF) begin
      errs++; $display("FAIL trunc_wrap got=%b/%h exp=1/3ff", rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic signed [9:0] la [2][2];
    logic signed [9:0] lb [2][2];
    int                k [2];
    logic [1:0]        pend;
    logic [3:0]        acc;
    logic [11:0]       q [$];
    int                nacc_stall;
    int                ndrained;
    la[0][0] = 10'sd5;  lb[0][0] = 10'sd7;
    la[0][1] = 10'sd2;  lb[0][1] = 10'sd3;
    la[1][0] = -10'sd6; lb[1][0] = 10'sd9;
    la[1][1] = 10'sd4;  lb[1][1] = 10'sd4;
    k = '{0, 0};
    pend = 2'b00;
    nacc_stall = 0;
    ndrained = 0;
    @(negedge clk);
    oa[0] = la[0][0]; ob[0] = lb[0][0];
    oa[1] = la[1][0]; ob[1] = lb[1][0];
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      // Requesters move to their next operation only after the edge that accepted them
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          k[i]++;
          if (k[i] == 2) req_valid[i] = 1'b0;
          else begin oa[i] = la[i][k[i]]; ob[i] = lb[i][k[i]]; end
        end
      end
      rsp_ready = (c >= 5);
      #1;
      if (rsp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errs++; $display("FAIL bp_rsp[%0d] got=%0d/%h exp=none", c, rsp_id, rsp_data);
        end else if ({rsp_id, rsp_data} !== q[0]) begin
          errs++; $display("FAIL bp_rsp[%0d] got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_data, q[0][11:10], q[0][9:0]);
        end
        if (rsp_ready && q.size() > 0) begin
          void'(q.pop_front());
          ndrained++;
        end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (req_ready !== 4'h0) begin errs++; $display("FAIL bp_full[%0d] got=%b exp=0000", c, req_ready); end
      end
      acc = req_valid & req_ready;
      pend = acc[1:0];
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          q.push_back({2'(i), low_prod(oa[i], ob[i])});
          if (c < 5) nacc_stall++;
        end
      end
    end
    checks++; if (nacc_stall !== 2) begin errs++; $display("FAIL bp_accepts got=%0d exp=2", nacc_stall); end
    checks++; if (ndrained !== 4) begin errs++; $display("FAIL bp_drained got=%0d exp=4", ndrained); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_idle got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    oa[1] = 10'sd1; ob[1] = 10'sd1;
    oa[2] = 10'sd2; ob[2] = 10'sd2;
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || mul_din0 !== 10'h001) begin
      errs++; $display("FAIL mid_full got=%b/%h exp=1/001", rsp_valid, mul_din0);
    end
    #1;
    ap_rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_async_valid got=%b exp=0", rsp_valid); end
    checks++; if (mul_din0 !== 10'h000) begin errs++; $display("FAIL mid_din0 got=%h exp=000", mul_din0); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'h0) begin errs++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
`ifdef CONVN_MUL_SHARE_PERF_EN
    checks++; if (perf_ops !== 16'h0) begin errs++; $display("FAIL mid_perf_ops got=%h exp=0", perf_ops); end
    checks++; if (perf_stall !== 16'h0) begin errs++; $display("FAIL mid_perf_stall got=%h exp=0", perf_stall); end
`endif
    @(negedge clk);
    ap_rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_rr_zero got=%b exp=0001", req_ready); end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL mid_stale[%0d] got=%b exp=0", c, rsp_valid); end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    ap_rst_n = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      oa[i] = '0;
      ob[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/convn_valid_mul_share.md
# convn_valid_mul_share

Round-robin arbiter and two-stage pipeline that time-shares a single external signed 10x10 multiplier (low 10 product bits) among `NREQ` requesters inside the `convn_valid` datapath. It accepts operand pairs over valid/ready handshakes and registers them onto the multiplier inputs. It captures the product and returns it on one shared response channel tagged with the requester index. The multiplier itself stays a separate combinational instance; this block only drives and samples it.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 10: operand width, signed.
- `PW`, 10: product width returned by the multiplier.
- `IDW`, 2: requester-id width, equals ceil(log2(NREQ)).

- `ap_clk`  in  1  clock; all state updates on the rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*DW  operand A; requester i occupies bits [i*DW +: DW].
- `req_b`  in  NREQ*DW  operand B, same packing as `req_a`.
- `mul_din0`  out  DW  to the multiplier `din0`; driven from a register.
- `mul_din1`  out  DW  to the multiplier `din1`; driven from a register.
- `mul_dout`  in  PW  product from the multiplier, combinational from `mul_din0`/`mul_din1`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_data`  out  PW  product.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.

## Operation
- Stage S1 holds the operand registers: `s1_v`, `s1_a`, `s1_b`, `s1_id`. The multiplier reads `s1_a`/`s1_b` through `mul_din0`/`mul_din1`.
- Stage S2 holds the response registers: `rsp_valid`, `rsp_data`, `rsp_id`.
- Advance conditions:
  - `s2_free = !rsp_valid | rsp_ready`.
  - `s1_adv = s1_v & s2_free`.
  - `s1_free = !s1_v | s1_adv`.
- Arbitration: round-robin pointer `rr`, reset 0.
  - Grant goes to the first i with `req_valid[i]=1`, searching from `rr` upward modulo NREQ.
  - `req_ready[i] = s1_free & grant[i]`.
  - On an accept by requester g: `rr <= (g+1) mod NREQ`. With no accept, `rr` holds.
- Accept (`req_valid[g] & req_ready[g]`) loads S1 with `req_a[g]`, `req_b[g]` and id g, and sets `s1_v=1`. If `s1_adv` occurs with no accept, S1 clears `s1_v`. `s1_a`/`s1_b` keep their values.
- `s1_adv` loads S2 with `rsp_data <= mul_dout` and `rsp_id <= s1_id`, and sets `rsp_valid=1`. A response handshake with no `s1_adv` clears `rsp_valid`.
- Arithmetic: `rsp_data` is the low PW bits of the signed DW x DW product, unchanged from the multiplier. The block performs no further rounding or wrap handling.
- Requester protocol: requesters hold valid and operands stable until `req_ready`. `req_valid` does not depend on `req_ready`.
- Reset, whether asserted idle or mid-operation:
  - Clears `s1_v`, `rsp_valid`, `rr`, and all data and id registers to 0.
  - `req_ready` is 0 while `ap_rst_n=0`.
  - In-flight operations are discarded; no response is produced for them.

## Timing
- Latency: an accept at edge k gives `rsp_valid=1` after edge k+1, provided `rsp_ready` was not blocking at k+1.
- Throughput: one operation per cycle while `rsp_ready=1`.
- Backpressure:
  - With `rsp_ready=0` and `rsp_valid=1`, S2 holds and S1 holds.
  - If S1 is full, `req_ready` is all 0.
  - At most 2 operations are in flight.
- Simultaneous events:
  - A response handshake, an S1 advance and a new accept can all occur in the same cycle. This is required for full throughput.
  - `rr` updates only on an accept, never on a response.
- `mul_din0`/`mul_din1` are registers, so there is no combinational path from `req_*` to the multiplier.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `s1_v`.

## Configuration
- `CONVN_MUL_SHARE_PERF_EN` defined:
  - Adds output ports `perf_ops` [15:0] and `perf_stall` [15:0], both reset to 0.
  - `perf_ops` increments on each request accept.
  - `perf_stall` increments on each cycle where `req_valid != 0` and `req_ready == 0` outside reset.
  - Both saturate at 16'hFFFF.
- `CONVN_MUL_SHARE_PERF_EN` undefined: the ports and counters are absent, with no other behavioural difference.

## Test plan
- Reset: hold `ap_rst_n=0` with `req_valid=4'hF`.
  - Required: `req_ready=0`, `rsp_valid=0`, `mul_din0=mul_din1=0`.
  - After release, the first grant goes to requester 0.
- Single operation: requester 2 presents a=3, b=-4; `rsp_ready=1`; a behavioural 10s_10s_10 model is attached.
  - Required: accept at edge k.
  - Required: after edge k+1, `rsp_valid=1`, `rsp_data=10'h3F4`, `rsp_id=2`, for exactly one cycle.
- Round-robin: all 4 requesters valid continuously, `rsp_ready=1`.
  - Required: grants 0,1,2,3,0,1 on consecutive cycles, back-to-back responses, one per cycle.
- Truncation: a=-512, b=-512.
  - Required: `rsp_data=10'h000`.
  - Then a=31, b=33: `rsp_data=10'h3FF`.
- Backpressure: hold `rsp_ready=0` for 5 cycles while requesters 0 and 1 stream.
  - Required: exactly 2 accepts, then `req_ready=0`.
  - `rsp_data`/`rsp_id` stable through the stall.
  - On release, responses drain in order with none lost or duplicated.
- Mid-operation reset: assert `ap_rst_n` with both stages full.
  - Required: `rsp_valid` drops asynchronously, no stale response after release, and `rr=0`.
  - With `CONVN_MUL_SHARE_PERF_EN`: `perf_ops` and `perf_stall` both read 0.
